// File: rtl/uart_pkg.sv
// Shared constants and types for the UART loopback transmit buffer.
package uart_pkg;
  localparam int DEF_PACK_SIZE = 8;
  localparam int CLK_PER_BIT   = 868;  // 100 MHz / 115200 baud

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    WAIT_DONE
  } tx_buf_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and no fall-through.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty_q;
  assign do_push = push & (~full_q | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = cnt_q;
endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers received bytes and paces them into the UART transmitter one at a time.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int PACK_SIZE = DEF_PACK_SIZE,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [PACK_SIZE-1:0]   in_data,
  input  logic                   tx_active,
  input  logic                   tx_done,
  input  logic                   clr_ovf,
  output logic                   tx_byte_valid,
  output logic [PACK_SIZE-1:0]   tx_byte_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);
  tx_buf_state_t        state_q, state_d;
  logic                 launch, drop;
  logic                 ovf_q, ovf_d;
  logic                 vld_q;
  logic [PACK_SIZE-1:0] data_q, head;

  sync_fifo #(.WIDTH(PACK_SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (launch),
    .wdata (in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign launch = (state_q == IDLE) & ~empty & ~tx_active;
  assign drop   = in_valid & full & ~launch;

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE:       if (launch) state_d = WAIT_START;
      // A transmitter that finishes before we ever see it busy still releases us.
      WAIT_START: if (tx_done) state_d = IDLE;
                  else if (tx_active) state_d = WAIT_DONE;
      WAIT_DONE:  if (tx_done) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      vld_q   <= launch;
      if (launch) data_q <= head;
    end
  end

  assign tx_byte_valid = vld_q;
  assign tx_byte_data  = data_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench: accepted bytes are queued on push and matched on each launch.
module tb_uart_tx_buffer;
  localparam int PW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, clr_ovf;
  logic [PW-1:0] in_data;
  logic          tx_active, tx_done;
  logic          tx_byte_valid;
  logic [PW-1:0] tx_byte_data;
  logic [CW-1:0] count;
  logic          full, empty, overflow;

  logic hold_busy, model_busy, model_done;
  int   tx_lat;
  int   n_checks = 0;
  int   n_err    = 0;
  int   launches = 0;
  logic [PW-1:0] exp_q [$];

  assign tx_active = hold_busy | model_busy;
  assign tx_done   = model_done;

  always #5 clk = ~clk;

  uart_tx_buffer #(.PACK_SIZE(PW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .tx_active     (tx_active),
    .tx_done       (tx_done),
    .clr_ovf       (clr_ovf),
    .tx_byte_valid (tx_byte_valid),
    .tx_byte_data  (tx_byte_data),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Transmitter model: goes busy after a launch, pulses done tx_lat cycles later.
  initial begin
    model_busy = 1'b0;
    model_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_byte_valid) begin
        @(posedge clk); #1 model_busy = 1'b1;
        repeat (tx_lat) @(posedge clk);
        #1 model_busy = 1'b0; model_done = 1'b1;
        @(posedge clk); #1 model_done = 1'b0;
      end
    end
  end

  // Launch monitor: ordering, no back-to-back strobes, nothing unexpected.
  initial begin
    logic prev_vld;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_byte_valid) begin
        launches++;
        chk("b2b_valid", {31'b0, prev_vld}, 32'd0);
        chk("sb_has_entry", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) chk("tx_data", tx_byte_data, exp_q.pop_front());
      end
      prev_vld = tx_byte_valid;
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that sampled the byte.
  task automatic push_byte(input logic [PW-1:0] b, input bit acc, input bit clr = 1'b0);
    in_valid = 1'b1; in_data = b; clr_ovf = clr;
    if (acc) exp_q.push_back(b);
    @(posedge clk); #1;
    in_valid = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && empty && !model_busy && !model_done && !tx_byte_valid;
    end
    chk(tag, {31'b0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_model_idle(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      done = !model_busy && !model_done;
    end
    chk("model_idle_timeout", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic single_launch(input string tag, input logic [PW-1:0] b);
    push_byte(b, 1'b1);
    @(negedge clk);
    chk({tag, "_cnt1"}, count, 32'd1);
    chk({tag, "_vld0"}, tx_byte_valid, 32'd0);
    @(negedge clk);
    chk({tag, "_vld1"}, tx_byte_valid, 32'd1);
    chk({tag, "_data"}, tx_byte_data, b);
    chk({tag, "_cnt0"}, count, 32'd0);
    wait_drain({tag, "_drain"}, 500);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clr_ovf = 1'b0;
    hold_busy = 1'b0; tx_lat = 20;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", count, 32'd0);
    chk("rst_empty", empty, 32'd1);
    chk("rst_full", full, 32'd0);
    chk("rst_ovf", overflow, 32'd0);
    chk("rst_vld", tx_byte_valid, 32'd0);
    chk("rst_data", tx_byte_data, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    single_launch("single", 8'hA5);

    // Burst with slow transmitter
    tx_lat = 100;
    base = launches;
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b1);
    wait_drain("burst_drain", 2000);
    chk("burst_launches", launches - base, 32'd5);

    // Overflow with transmitter held busy
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i), 1'b1);
    @(negedge clk);
    chk("ovf_full", full, 32'd1);
    chk("ovf_cnt", count, DEPTH);
    chk("ovf_pre", overflow, 32'd0);
    @(posedge clk); #1;
    push_byte(8'hEE, 1'b0);
    @(negedge clk);
    chk("ovf_set", overflow, 32'd1);
    chk("ovf_cnt_drop", count, DEPTH);
    @(posedge clk); #1;
    push_byte(8'hEF, 1'b0, 1'b1);
    @(negedge clk);
    chk("ovf_drop_beats_clr", overflow, 32'd1);
    chk("ovf_cnt_drop2", count, DEPTH);
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clr", overflow, 32'd0);
    chk("ovf_cnt_clr", count, DEPTH);

    // Full: push in the launch cycle is accepted
    @(posedge clk); #1;
    tx_lat = 5;
    hold_busy = 1'b0;
    push_byte(8'h7E, 1'b1);
    @(negedge clk);
    chk("fullpp_vld", tx_byte_valid, 32'd1);
    chk("fullpp_cnt", count, DEPTH);
    chk("fullpp_full", full, 32'd1);
    chk("fullpp_ovf", overflow, 32'd0);
    wait_drain("fullpp_drain", 1000);

    // Reset while in WAIT_DONE with 3 bytes buffered
    tx_lat = 200;
    for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i), 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_cnt3", count, 32'd3);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    #2;
    chk("mrst_cnt", count, 32'd0);
    chk("mrst_empty", empty, 32'd1);
    chk("mrst_full", full, 32'd0);
    chk("mrst_vld", tx_byte_valid, 32'd0);
    chk("mrst_data", tx_byte_data, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_model_idle(500);
    tx_lat = 10;
    single_launch("postrst", 8'h3C);

    // Wrap-around: three fill/drain rounds
    tx_lat = 2;
    base = launches;
    for (int r = 0; r < 3; r++) begin
      hold_busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h40 + r * DEPTH + i), 1'b1);
      hold_busy = 1'b0;
      wait_drain("wrap_drain", 1000);
    end
    chk("wrap_launches", launches - base, 3 * DEPTH);
    chk("final_empty", empty, 32'd1);
    chk("final_sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
